// File: rtl/xorshift_prng_stream.sv
// Xorshift pseudo-random word source with a valid/ready output stream, seed load,
// enable and an accepted-word counter. WIDTH selects the 32- or 64-bit shift triple.

module xorshift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_x
);
  localparam int SH_A = 13;
  localparam int SH_B = (WIDTH == 64) ? 7  : 17;
  localparam int SH_C = (WIDTH == 64) ? 17 : 5;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  assign w_a = i_x ^ (i_x << SH_A);
  assign w_b = w_a ^ (w_a >> SH_B);
  assign o_x = w_b ^ (w_b << SH_C);
endmodule

module xorshift_prng_stream #(
  parameter int               WIDTH      = 32,
  parameter int               STEPS      = 4,
  parameter logic [WIDTH-1:0] RESET_SEED = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_count
);
  generate
    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $error("xorshift_prng_stream: WIDTH must be 32 or 64");
    end
    if (STEPS < 1) begin : g_bad_steps
      $error("xorshift_prng_stream: STEPS must be >= 1");
    end
    if (RESET_SEED == '0) begin : g_bad_seed
      $error("xorshift_prng_stream: RESET_SEED must be non-zero");
    end
  endgenerate

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [31:0]      r_count;

  logic [STEPS:0][WIDTH-1:0] w_chain;
  logic [WIDTH-1:0]          w_next;
  logic [WIDTH-1:0]          w_seed;
  logic                      w_hs;
  logic                      w_slot_free;
  logic                      w_emit;

  // Unrolled chain: STEPS iterations land in a single cycle.
  assign w_chain[0] = r_state;

  generate
    for (genvar g = 0; g < STEPS; g++) begin : g_step
      xorshift_step #(.WIDTH(WIDTH)) u_step (
        .i_x (w_chain[g]),
        .o_x (w_chain[g+1])
      );
    end
  endgenerate

  assign w_next      = w_chain[STEPS];
  // A zero seed would lock the generator at zero forever.
  assign w_seed      = (seed_data == '0) ? RESET_SEED : seed_data;
  assign w_hs        = r_valid & out_ready;
  assign w_slot_free = ~r_valid | out_ready;
  assign w_emit      = w_slot_free & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_SEED;
    end else if (seed_load) begin
      r_state <= w_seed;
    end else if (w_emit) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (seed_load) begin
      r_valid <= 1'b0;
    end else if (w_emit) begin
      r_data  <= r_state;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (seed_load) begin
      r_count <= '0;
    end else if (w_hs) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_count = r_count;
endmodule

// File: tb/tb_xorshift_prng_stream.sv
// Scoreboard bench for xorshift_prng_stream: three instances (32b/1 step, defaults,
// 64b/2 steps) each checked against an independent word-sequence model.

module tb_xorshift_prng_stream;
  logic clk = 1'b0;
  logic rst_n;

  logic        en0, ld0, r0, v0;
  logic [31:0] sd0, d0, c0;
  logic        en1, ld1, r1, v1;
  logic [31:0] sd1, d1, c1;
  logic        en2, ld2, r2, v2;
  logic [63:0] sd2, d2;
  logic [31:0] c2;

  always #5 clk = ~clk;

  xorshift_prng_stream #(.WIDTH(32), .STEPS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .seed_load(ld0), .seed_data(sd0),
    .out_data(d0), .out_valid(v0), .out_ready(r0), .out_count(c0));

  xorshift_prng_stream u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .seed_load(ld1), .seed_data(sd1),
    .out_data(d1), .out_valid(v1), .out_ready(r1), .out_count(c1));

  xorshift_prng_stream #(.WIDTH(64), .STEPS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .seed_load(ld2), .seed_data(sd2),
    .out_data(d2), .out_valid(v2), .out_ready(r2), .out_count(c2));

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt [3];
  logic [63:0] q0[$], q1[$], q2[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int wid(int i);
    return (i == 2) ? 64 : 32;
  endfunction

  function automatic int stp(int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] rstv(int i);
    return (wid(i) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] mstep(int w, logic [63:0] x);
    logic [31:0] y;
    logic [63:0] z;
    if (w == 32) begin
      y = x[31:0];
      y = y ^ (y << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return {32'd0, y};
    end
    z = x;
    z = z ^ (z << 13);
    z = z ^ (z >> 7);
    z = z ^ (z << 17);
    return z;
  endfunction

  function automatic logic [63:0] mstepn(int i, logic [63:0] x);
    logic [63:0] z = x;
    for (int k = 0; k < stp(i); k++) z = mstep(wid(i), z);
    return z;
  endfunction

  function automatic int q_size(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int i, input logic [63:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int i, output logic [63:0] v);
    case (i)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic q_flush(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Words leave in seed, F^S(seed), F^2S(seed)... order regardless of timing.
  task automatic mdl_load(input int i, input logic [63:0] s);
    logic [63:0] st;
    m_cnt[i] = 0;
    q_flush(i);
    st = (s == 64'd0) ? rstv(i) : s;
    for (int k = 0; k < 64; k++) begin
      q_push(i, st);
      st = mstepn(i, st);
    end
  endtask

  task automatic mdl_reset_all();
    for (int i = 0; i < 3; i++) mdl_load(i, 64'd0);
  endtask

  function automatic logic [63:0] dat(int i);
    case (i)
      0:       return {32'd0, d0};
      1:       return {32'd0, d1};
      default: return d2;
    endcase
  endfunction

  function automatic logic vld(int i);
    case (i)
      0:       return v0 & r0;
      1:       return v1 & r1;
      default: return v2 & r2;
    endcase
  endfunction

  function automatic logic lda(int i);
    case (i)
      0:       return ld0;
      1:       return ld1;
      default: return ld2;
    endcase
  endfunction

  function automatic logic [63:0] cnt(int i);
    case (i)
      0:       return {32'd0, c0};
      1:       return {32'd0, c1};
      default: return {32'd0, c2};
    endcase
  endfunction

  // Monitor: inputs only change just after posedge, so negedge samples are stable.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!lda(i)) chk($sformatf("count%0d", i), cnt(i), 64'(m_cnt[i]));
        if (vld(i) && !lda(i)) begin
          chk($sformatf("sb_nonempty%0d", i), 64'(q_size(i) != 0), 64'd1);
          if (q_size(i) != 0) begin
            q_pop(i, e);
            chk($sformatf("word%0d", i), dat(i), e);
          end
          m_cnt[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] held, last;
  logic [31:0] cnt_h;

  initial begin
    rst_n = 1'b0;
    {en0, ld0, r0, en2, ld2, r2} = '0;
    sd0 = '0; sd1 = '0; sd2 = '0; ld1 = 1'b0;
    en1 = 1'b1; r1 = 1'b1;
    mdl_reset_all();
    #2;
    chk("rst_data0", {32'd0, d0}, 64'd0);
    chk("rst_valid1", 64'(v1), 64'd0);
    chk("rst_count1", {32'd0, c1}, 64'd0);
    chk("rst_valid2", 64'(v2), 64'd0);
    step();
    rst_n = 1'b1;

    // Defaults from reset: first word is the reset seed, full throughput.
    step(); @(negedge clk);
    chk("t2_first", {32'd0, d1}, 64'hFFFF_FFFF);
    chk("t2_valid", 64'(v1), 64'd1);
    step(); @(negedge clk);
    chk("t2_second", {32'd0, d1}, mstepn(1, 64'hFFFF_FFFF));
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      chk("t2_stream_valid", 64'(v1), 64'd1);
    end

    // Backpressure: word and count hold while ready is low, whatever en does.
    step();
    r1 = 1'b0;
    @(negedge clk);
    held = {32'd0, d1};
    cnt_h = c1;
    for (int k = 0; k < 5; k++) begin
      en1 = k[0];
      step(); @(negedge clk);
      chk("t3_hold_data", {32'd0, d1}, held);
      chk("t3_hold_valid", 64'(v1), 64'd1);
      chk("t3_hold_count", {32'd0, c1}, {32'd0, cnt_h});
    end
    en1 = 1'b1;
    step();
    r1 = 1'b1;
    step(); @(negedge clk);
    chk("t3_after_release", {32'd0, d1}, mstepn(1, held));

    // Zero seed during a live handshake: reset seed, count cleared, handshake dropped.
    step();
    ld1 = 1'b1; sd1 = 32'd0;
    mdl_load(1, 64'd0);
    step();
    ld1 = 1'b0;
    @(negedge clk);
    chk("t4_valid_low", 64'(v1), 64'd0);
    chk("t4_count_zero", {32'd0, c1}, 64'd0);
    step(); @(negedge clk);
    chk("t4_first", {32'd0, d1}, 64'hFFFF_FFFF);
    chk("t4_valid", 64'(v1), 64'd1);

    // en=0: current word drains, nothing new, then resume from frozen state.
    en1 = 1'b0;
    last = {32'd0, d1};
    step(); @(negedge clk);
    chk("t5_drained", 64'(v1), 64'd0);
    cnt_h = c1;
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      chk("t5_idle_valid", 64'(v1), 64'd0);
      chk("t5_idle_count", {32'd0, c1}, {32'd0, cnt_h});
    end
    en1 = 1'b1;
    step(); @(negedge clk);
    chk("t5_resume", {32'd0, d1}, mstepn(1, last));
    chk("t5_resume_valid", 64'(v1), 64'd1);
    step();
    r1 = 1'b0; en1 = 1'b0;

    // 32-bit single step, known vectors from seed 1.
    ld0 = 1'b1; sd0 = 32'd1;
    mdl_load(0, 64'd1);
    step();
    ld0 = 1'b0; en0 = 1'b1; r0 = 1'b1;
    step(); @(negedge clk);
    chk("t1_w0", {32'd0, d0}, 64'h0000_0001);
    step(); @(negedge clk);
    chk("t1_w1", {32'd0, d0}, 64'h0004_2021);
    chk("t1_cnt1", {32'd0, c0}, 64'd1);
    step(); @(negedge clk);
    chk("t1_w2", {32'd0, d0}, 64'h0408_0601);
    en0 = 1'b0;
    step(); @(negedge clk);
    chk("t1_cnt3", {32'd0, c0}, 64'd3);
    chk("t1_valid_low", 64'(v0), 64'd0);
    step();
    r0 = 1'b0;

    // 64-bit, two steps, async reset mid-stream.
    ld2 = 1'b1; sd2 = 64'd1;
    mdl_load(2, 64'd1);
    step();
    ld2 = 1'b0; en2 = 1'b1; r2 = 1'b1;
    step(); @(negedge clk);
    chk("t6_w0", d2, 64'd1);
    step(); @(negedge clk);
    chk("t6_w1", d2, mstepn(2, 64'd1));
    step();
    rst_n = 1'b0;
    mdl_reset_all();
    #1;
    chk("t6_async_valid", 64'(v2), 64'd0);
    chk("t6_async_count", {32'd0, c2}, 64'd0);
    chk("t6_async_data", d2, 64'd0);
    step();
    rst_n = 1'b1;
    step(); @(negedge clk);
    chk("t6_post_rst", d2, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); @(negedge clk);
    chk("t6_post_rst_next", d2, mstepn(2, 64'hFFFF_FFFF_FFFF_FFFF));
    step();
    en2 = 1'b0; r2 = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xorshift_prng_stream.md
Name: xorshift_prng_stream

Overview:
Parametrised xorshift pseudo-random source with a valid/ready output stream, runtime seed load, enable, and a handshake counter.
Generalises the fixed 32-bit free-running generator in three ways: selectable 32/64-bit width, STEPS iterations per output word, and backpressure-safe output.
Feeds randomised symbol and error-injection stimulus to the DNA encoder/channel models.

Parameters:
WIDTH, 32, state/output width; legal values 32 or 64 only (elaboration error otherwise).
STEPS, 4, xorshift iterations applied per accepted word; must be >= 1.
RESET_SEED, all-ones of WIDTH, state value after reset; a zero value is an elaboration error.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  permit generation of a new word.
seed_load  in  1  load seed_data into state this cycle.
seed_data  in  WIDTH  seed value.
out_data  out  WIDTH  random word.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts out_data.
out_count  out  32  number of accepted words since reset or last seed load.

Behaviour:
- Reset (async, rst_n=0): state=RESET_SEED; out_data=0; out_valid=0; out_count=0. Reset mid-stream drops any pending word.
- Step function F:
  - WIDTH=32: x^=x<<13; x^=x>>17; x^=x<<5.
  - WIDTH=64: x^=x<<13; x^=x>>7; x^=x<<17.
  - All shifts are logical and truncated to WIDTH.
  - Next state = F applied STEPS times, purely combinational, no extra latency.
- Priority per rising edge, highest first:
  1. seed_load=1:
     - state = (seed_data==0) ? RESET_SEED : seed_data.
     - out_valid=0; out_count=0.
     - A handshake in the same cycle is discarded and not counted.
  2. Else, when the output slot is free (out_valid=0, or out_valid=1 with out_ready=1) and en=1:
     - out_data = state; out_valid=1; state = F^STEPS(state).
  3. Else, when out_valid=1 and out_ready=1 and en=0: out_valid=0.
  4. Otherwise all registers hold.
- Handshake (out_valid and out_ready high on the same edge, no seed_load): out_count += 1, wrapping 2^32-1 -> 0.
- Output stability: while out_valid=1 and out_ready=0, out_data is held stable and state does not advance, regardless of en.
- First word emitted after reset or seed load equals the seed itself; the generator never reaches state 0.
- Latency: the first enabled edge after a load/reset raises out_valid. With en=1 and out_ready=1 held continuously, one new word is presented every cycle (full throughput).
- out_valid never depends combinationally on out_ready; all outputs are registered.

Test Plan:
1. WIDTH=32, STEPS=1, seed_load with seed_data=0x00000001, then en=1, out_ready=1 -> out_data sequence 0x00000001, 0x00042021, 0x04080601; out_count=3 after three handshakes.
2. Reset release, en=1, out_ready=1, defaults -> first out_data=0xFFFFFFFF; second out_data = F^4(0xFFFFFFFF) matching the reference model; out_valid high every cycle.
3. Backpressure: out_ready=0 for 5 cycles with en=1 -> out_data and out_valid=1 held constant, out_count unchanged; out_ready=1 -> next word equals F^STEPS of the held word.
4. seed_load asserted with seed_data=0 during an active handshake -> state=RESET_SEED, out_valid=0 next cycle, out_count=0, the discarded handshake is not counted.
5. en=0 with out_ready=1 after a valid word -> out_valid drops after one handshake; no further words; state frozen; en=1 resumes from the frozen state.
6. WIDTH=64, STEPS=2: seed 0x1, async reset pulsed mid-stream -> outputs match the model; reset drives out_valid=0, out_count=0 immediately, without waiting for a clock edge.
